// File: rtl/pipe_controller.sv
// Pipelined RISC-V control unit: D-stage decode, E/M/W control registers,
// cache-miss / load-use / flush hazard handling and saturating stall counters.

module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_cnt <= '0;
    else if (i_inc && r_cnt != '1)     r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

module pipe_controller #(
  parameter int ALUC_W     = 3,
  parameter int ENABLE_MUL = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rs1D,
  input  logic [4:0]        rs2D,
  input  logic [4:0]        rdD,
  input  logic              flush,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              illegalD,
  output logic              ALUSrcE,
  output logic              BranchE,
  output logic              JumpE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic [4:0]        rdE,
  output logic [4:0]        rdM,
  output logic [4:0]        rdW,
  output logic              MemWriteM,
  output logic              LoadM,
  output logic              ByteM,
  output logic              BranchM,
  output logic              JumpM,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic              ByteW,
  output logic [CNT_W-1:0]  cnt_imiss,
  output logic [CNT_W-1:0]  cnt_dmiss,
  output logic [CNT_W-1:0]  cnt_loaduse
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       load;
    logic       byte_sel;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [2:0] aluc;
    logic [4:0] rd;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       load;
    logic       byte_sel;
    logic       branch;
    logic       jump;
    logic [4:0] rd;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       byte_sel;
    logic [4:0] rd;
  } ctrl_w_t;

  ctrl_e_t r_e;
  ctrl_m_t r_m;
  ctrl_w_t r_w;

  ctrl_e_t w_dec;
  ctrl_e_t w_bund;
  logic    w_legal;
  logic    w_dmiss;
  logic    w_loaduse;
  logic    w_e_kill;

  // ---------------- D-stage decode ----------------
  always_comb begin
    w_dec    = '0;
    w_dec.rd = rdD;
    w_legal  = 1'b1;
    case (opcode)
      OP_R: begin
        w_dec.reg_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  w_dec.aluc = ALU_ADD;
            3'b111:  w_dec.aluc = ALU_AND;
            3'b110:  w_dec.aluc = ALU_OR;
            3'b010:  w_dec.aluc = ALU_SLT;
            3'b100:  w_dec.aluc = ALU_XOR;
            default: w_legal    = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          w_dec.aluc = ALU_SUB;
        end else if (ENABLE_MUL != 0 && funct7 == 7'b0000001 && funct3 == 3'b000) begin
          w_dec.aluc = ALU_MUL;
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_I: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        case (funct3)
          3'b000:  w_dec.aluc = ALU_ADD;
          3'b111:  w_dec.aluc = ALU_AND;
          3'b110:  w_dec.aluc = ALU_OR;
          3'b010:  w_dec.aluc = ALU_SLT;
          3'b100:  w_dec.aluc = ALU_XOR;
          default: w_legal    = 1'b0;
        endcase
      end
      OP_LD: begin
        w_dec.reg_write = 1'b1;
        w_dec.load      = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.byte_sel  = (funct3 == 3'b000);
        w_legal         = (funct3 == 3'b000) || (funct3 == 3'b010);
      end
      OP_ST: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.byte_sel  = (funct3 == 3'b000);
        w_legal         = (funct3 == 3'b000) || (funct3 == 3'b010);
      end
      OP_BR: begin
        w_dec.branch = 1'b1;
        w_dec.aluc   = ALU_SUB;
        w_legal      = (funct3 == 3'b000);
      end
      OP_JAL: begin
        w_dec.jump      = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    w_bund = w_legal ? w_dec : '0;
  end

  assign illegalD = ihit & ~w_legal;

  // ---------------- hazards, highest priority first ----------------
  assign w_dmiss   = (r_m.load | r_m.mem_write) & ~dhit;
  assign w_loaduse = r_e.load & (r_e.rd != 5'd0) &
                     ((r_e.rd == rs1D) | (r_e.rd == rs2D)) & ihit;
  assign w_e_kill  = flush | w_loaduse | ~ihit;

  assign stallF = w_dmiss | (~flush & (w_loaduse | ~ihit));
  assign stallD = w_dmiss | (~flush & w_loaduse);
  assign flushD = ~w_dmiss & flush;

  // A data miss freezes E and M in place; only W drains into a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else if (w_dmiss) begin
      r_w <= '0;
    end else begin
      r_e <= w_e_kill ? '0 : w_bund;
      r_m.reg_write  <= r_e.reg_write;
      r_m.mem_write  <= r_e.mem_write;
      r_m.load       <= r_e.load;
      r_m.byte_sel   <= r_e.byte_sel;
      r_m.branch     <= r_e.branch;
      r_m.jump       <= r_e.jump;
      r_m.rd         <= r_e.rd;
      r_w.reg_write  <= r_m.reg_write;
      r_w.mem_to_reg <= r_m.load;
      r_w.byte_sel   <= r_m.byte_sel;
      r_w.rd         <= r_m.rd;
    end
  end

  assign ALUSrcE     = r_e.alu_src;
  assign BranchE     = r_e.branch;
  assign JumpE       = r_e.jump;
  assign ALUControlE = ALUC_W'(r_e.aluc);
  assign rdE         = r_e.rd;
  assign rdM         = r_m.rd;
  assign MemWriteM   = r_m.mem_write;
  assign LoadM       = r_m.load;
  assign ByteM       = r_m.byte_sel;
  assign BranchM     = r_m.branch;
  assign JumpM       = r_m.jump;
  assign rdW         = r_w.rd;
  assign RegWriteW   = r_w.reg_write;
  assign MemtoRegW   = r_w.mem_to_reg;
  assign ByteW       = r_w.byte_sel;

  // ---------------- performance counters ----------------
  pipe_sat_cnt #(.W(CNT_W)) u_cnt_dmiss (
    .clk(clk), .reset(reset), .i_inc(w_dmiss), .o_cnt(cnt_dmiss)
  );
  pipe_sat_cnt #(.W(CNT_W)) u_cnt_loaduse (
    .clk(clk), .reset(reset), .i_inc(~w_dmiss & ~flush & w_loaduse), .o_cnt(cnt_loaduse)
  );
  pipe_sat_cnt #(.W(CNT_W)) u_cnt_imiss (
    .clk(clk), .reset(reset), .i_inc(~w_dmiss & ~flush & ~ihit), .o_cnt(cnt_imiss)
  );
endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: two configurations side by side, an instruction-level
// pipeline model checked every cycle, plus hand-computed literal checkpoints.

module tb_pipe_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ihit = 1'b1, dhit = 1'b1, flush = 1'b0;
  logic [6:0] opcode = 7'b0010011, funct7 = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [4:0] rs1D = 5'd0, rs2D = 5'd0, rdD = 5'd0;

  always #5 clk = ~clk;

  // u0: defaults (no MUL, 16-bit counters); u1: MUL enabled, 4-bit ALUControl, 2-bit counters
  logic a_sF, a_sD, a_fD, a_ill, a_aS, a_bE, a_jE, a_mwM, a_ldM, a_byM, a_brM, a_jpM, a_rwW, a_mtW, a_byW;
  logic [2:0] a_alu;
  logic [4:0] a_rE, a_rM, a_rW;
  logic [15:0] a_ci, a_cd, a_cl;
  logic b_sF, b_sD, b_fD, b_ill, b_aS, b_bE, b_jE, b_mwM, b_ldM, b_byM, b_brM, b_jpM, b_rwW, b_mtW, b_byW;
  logic [3:0] b_alu;
  logic [4:0] b_rE, b_rM, b_rW;
  logic [1:0] b_ci, b_cd, b_cl;

  pipe_controller u0 (
    .clk(clk), .reset(reset), .ihit(ihit), .dhit(dhit), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .flush(flush),
    .stallF(a_sF), .stallD(a_sD), .flushD(a_fD), .illegalD(a_ill),
    .ALUSrcE(a_aS), .BranchE(a_bE), .JumpE(a_jE), .ALUControlE(a_alu),
    .rdE(a_rE), .rdM(a_rM), .rdW(a_rW),
    .MemWriteM(a_mwM), .LoadM(a_ldM), .ByteM(a_byM), .BranchM(a_brM), .JumpM(a_jpM),
    .RegWriteW(a_rwW), .MemtoRegW(a_mtW), .ByteW(a_byW),
    .cnt_imiss(a_ci), .cnt_dmiss(a_cd), .cnt_loaduse(a_cl)
  );

  pipe_controller #(.ALUC_W(4), .ENABLE_MUL(1), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .ihit(ihit), .dhit(dhit), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .flush(flush),
    .stallF(b_sF), .stallD(b_sD), .flushD(b_fD), .illegalD(b_ill),
    .ALUSrcE(b_aS), .BranchE(b_bE), .JumpE(b_jE), .ALUControlE(b_alu),
    .rdE(b_rE), .rdM(b_rM), .rdW(b_rW),
    .MemWriteM(b_mwM), .LoadM(b_ldM), .ByteM(b_byM), .BranchM(b_brM), .JumpM(b_jpM),
    .RegWriteW(b_rwW), .MemtoRegW(b_mtW), .ByteW(b_byW),
    .cnt_imiss(b_ci), .cnt_dmiss(b_cd), .cnt_loaduse(b_cl)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef enum {M_NOP, M_BAD, M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_XOR, M_MUL,
                M_ADDI, M_ANDI, M_ORI, M_SLTI, M_XORI, M_LB, M_LW, M_SB, M_SW, M_BEQ, M_JAL} mn_t;
  typedef struct { mn_t op; int rd; } slot_t;

  slot_t st[2][3];            // [config][0=E,1=M,2=W]
  int    ci[2], cd[2], cl[2];
  int    cmax[2] = '{65535, 3};

  function automatic mn_t classify(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input bit mul);
    if (op == 7'b0110011) begin
      if (f7 == 7'h00 && f3 == 3'd0) return M_ADD;
      if (f7 == 7'h00 && f3 == 3'd7) return M_AND;
      if (f7 == 7'h00 && f3 == 3'd6) return M_OR;
      if (f7 == 7'h00 && f3 == 3'd2) return M_SLT;
      if (f7 == 7'h00 && f3 == 3'd4) return M_XOR;
      if (f7 == 7'h20 && f3 == 3'd0) return M_SUB;
      if (mul && f7 == 7'h01 && f3 == 3'd0) return M_MUL;
      return M_BAD;
    end
    if (op == 7'b0010011) begin
      if (f3 == 3'd0) return M_ADDI;
      if (f3 == 3'd7) return M_ANDI;
      if (f3 == 3'd6) return M_ORI;
      if (f3 == 3'd2) return M_SLTI;
      if (f3 == 3'd4) return M_XORI;
      return M_BAD;
    end
    if (op == 7'b0000011) return (f3 == 3'd0) ? M_LB : (f3 == 3'd2) ? M_LW : M_BAD;
    if (op == 7'b0100011) return (f3 == 3'd0) ? M_SB : (f3 == 3'd2) ? M_SW : M_BAD;
    if (op == 7'b1100011) return (f3 == 3'd0) ? M_BEQ : M_BAD;
    if (op == 7'b1101111) return M_JAL;
    return M_BAD;
  endfunction

  function automatic bit is_ld(input mn_t m); return m inside {M_LB, M_LW}; endfunction
  function automatic bit is_st(input mn_t m); return m inside {M_SB, M_SW}; endfunction
  function automatic bit is_byte(input mn_t m); return m inside {M_LB, M_SB}; endfunction
  function automatic bit uses_imm(input mn_t m);
    return m inside {M_ADDI, M_ANDI, M_ORI, M_SLTI, M_XORI, M_LB, M_LW, M_SB, M_SW};
  endfunction
  function automatic bit writes_rf(input mn_t m);
    return m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_XOR, M_MUL,
                     M_ADDI, M_ANDI, M_ORI, M_SLTI, M_XORI, M_LB, M_LW, M_JAL};
  endfunction
  function automatic int alu_of(input mn_t m);
    case (m)
      M_SUB, M_BEQ:   return 1;
      M_AND, M_ANDI:  return 2;
      M_OR,  M_ORI:   return 3;
      M_SLT, M_SLTI:  return 4;
      M_MUL:          return 5;
      M_XOR, M_XORI:  return 6;
      default:        return 0;
    endcase
  endfunction

  function automatic bit m_dmiss(input int k);
    return (is_ld(st[k][1].op) || is_st(st[k][1].op)) && !dhit;
  endfunction
  function automatic bit m_loaduse(input int k);
    return is_ld(st[k][0].op) && st[k][0].rd != 0 &&
           (st[k][0].rd == int'(rs1D) || st[k][0].rd == int'(rs2D)) && ihit;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int s = 0; s < 3; s++) st[k][s] = '{M_NOP, 0};
        ci[k] = 0; cd[k] = 0; cl[k] = 0;
      end else begin
        bit dm, lu;
        mn_t m;
        dm = m_dmiss(k);
        lu = m_loaduse(k);
        if (dm) begin
          st[k][2] = '{M_NOP, 0};
          if (cd[k] < cmax[k]) cd[k]++;
        end else begin
          st[k][2] = st[k][1];
          st[k][1] = st[k][0];
          m = classify(opcode, funct3, funct7, k == 1);
          if (flush) st[k][0] = '{M_NOP, 0};
          else if (lu) begin st[k][0] = '{M_NOP, 0}; if (cl[k] < cmax[k]) cl[k]++; end
          else if (!ihit) begin st[k][0] = '{M_NOP, 0}; if (ci[k] < cmax[k]) ci[k]++; end
          else if (m == M_BAD) st[k][0] = '{M_NOP, 0};
          else st[k][0] = '{m, int'(rdD)};
        end
      end
    end
  end

  task automatic cmp(input int k, input logic sF, input logic sD, input logic fD, input logic ill,
                     input logic aS, input logic bE, input logic jE, input logic [31:0] alu,
                     input logic [31:0] rE, input logic [31:0] rM, input logic [31:0] rW,
                     input logic mwM, input logic ldM, input logic byM, input logic brM,
                     input logic jpM, input logic rwW, input logic mtW, input logic byW,
                     input logic [31:0] xci, input logic [31:0] xcd, input logic [31:0] xcl);
    bit eF, eD, eFD;
    slot_t e, m, w;
    string p;
    p = (k == 0) ? "u0." : "u1.";
    e = st[k][0]; m = st[k][1]; w = st[k][2];
    if (m_dmiss(k))       begin eF = 1; eD = 1; eFD = 0; end
    else if (flush)       begin eF = 0; eD = 0; eFD = 1; end
    else if (m_loaduse(k)) begin eF = 1; eD = 1; eFD = 0; end
    else if (!ihit)       begin eF = 1; eD = 0; eFD = 0; end
    else                  begin eF = 0; eD = 0; eFD = 0; end
    chk({p, "stallF"}, sF, eF);
    chk({p, "stallD"}, sD, eD);
    chk({p, "flushD"}, fD, eFD);
    chk({p, "illegalD"}, ill, ihit && classify(opcode, funct3, funct7, k == 1) == M_BAD);
    chk({p, "ALUSrcE"}, aS, uses_imm(e.op));
    chk({p, "BranchE"}, bE, e.op == M_BEQ);
    chk({p, "JumpE"}, jE, e.op == M_JAL);
    chk({p, "ALUControlE"}, alu, alu_of(e.op));
    chk({p, "rdE"}, rE, e.rd);
    chk({p, "rdM"}, rM, m.rd);
    chk({p, "rdW"}, rW, w.rd);
    chk({p, "MemWriteM"}, mwM, is_st(m.op));
    chk({p, "LoadM"}, ldM, is_ld(m.op));
    chk({p, "ByteM"}, byM, is_byte(m.op));
    chk({p, "BranchM"}, brM, m.op == M_BEQ);
    chk({p, "JumpM"}, jpM, m.op == M_JAL);
    chk({p, "RegWriteW"}, rwW, writes_rf(w.op));
    chk({p, "MemtoRegW"}, mtW, is_ld(w.op));
    chk({p, "ByteW"}, byW, is_byte(w.op));
    chk({p, "cnt_imiss"}, xci, ci[k]);
    chk({p, "cnt_dmiss"}, xcd, cd[k]);
    chk({p, "cnt_loaduse"}, xcl, cl[k]);
  endtask

  always @(negedge clk) begin
    cmp(0, a_sF, a_sD, a_fD, a_ill, a_aS, a_bE, a_jE, a_alu, a_rE, a_rM, a_rW,
        a_mwM, a_ldM, a_byM, a_brM, a_jpM, a_rwW, a_mtW, a_byW, a_ci, a_cd, a_cl);
    cmp(1, b_sF, b_sD, b_fD, b_ill, b_aS, b_bE, b_jE, b_alu, b_rE, b_rM, b_rW,
        b_mwM, b_ldM, b_byM, b_brM, b_jpM, b_rwW, b_mtW, b_byW, b_ci, b_cd, b_cl);
  end

  // ---------------- stimulus ----------------
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JL = 7'b1101111;

  task automatic drv(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    opcode = op; funct3 = f3; funct7 = f7; rs1D = r1; rs2D = r2; rdD = rd;
    #1;
  endtask
  task automatic nop; drv(I, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0); endtask
  task automatic tick; @(posedge clk); #1; endtask

  typedef struct { logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic [4:0] r1; logic [4:0] rd; } vec_t;
  vec_t tbl[16] = '{
    '{LD, 3'd0, 7'h00, 5'd0,  5'd10},  // LB x10
    '{R,  3'd4, 7'h00, 5'd10, 5'd11},  // XOR depends on x10: load-use
    '{R,  3'd4, 7'h00, 5'd10, 5'd11},
    '{ST, 3'd0, 7'h00, 5'd1,  5'd2 },
    '{R,  3'd6, 7'h00, 5'd1,  5'd12},
    '{R,  3'd7, 7'h00, 5'd1,  5'd13},
    '{R,  3'd2, 7'h00, 5'd1,  5'd14},
    '{I,  3'd7, 7'h55, 5'd1,  5'd15},
    '{I,  3'd4, 7'h20, 5'd1,  5'd16},
    '{I,  3'd1, 7'h00, 5'd1,  5'd17},  // shift: not decodable
    '{LD, 3'd1, 7'h00, 5'd1,  5'd18},
    '{ST, 3'd4, 7'h00, 5'd1,  5'd19},
    '{BR, 3'd1, 7'h00, 5'd1,  5'd20},
    '{7'h7F, 3'd0, 7'h00, 5'd1, 5'd21},
    '{R,  3'd7, 7'h20, 5'd1,  5'd22},
    '{R,  3'd1, 7'h01, 5'd1,  5'd23}
  };

  initial begin
    nop;
    tick; tick;
    reset = 1'b0;
    // reset state
    chk("lit_reset_stallF", a_sF, 1'b0);
    chk("lit_reset_flushD", a_fD, 1'b0);
    chk("lit_reset_rdW", a_rW, 5'd0);
    chk("lit_reset_cnt_dmiss", a_cd, 16'd0);

    // ADD x5 flows E -> M -> W
    drv(R, 3'd0, 7'h00, 5'd1, 5'd2, 5'd5);
    tick;
    chk("lit_add_aluE", a_alu, 3'd0);
    chk("lit_add_rdE", a_rE, 5'd5);
    nop; tick; tick;
    chk("lit_add_rdW", a_rW, 5'd5);
    chk("lit_add_regwW", a_rwW, 1'b1);

    // LW x3 then ADD x4,x3,x1
    drv(LD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd3);
    tick;
    drv(R, 3'd0, 7'h00, 5'd3, 5'd1, 5'd4);
    chk("lit_lu_stallF", a_sF, 1'b1);
    chk("lit_lu_stallD", a_sD, 1'b1);
    tick;
    chk("lit_lu_bubbleE", a_rE, 5'd0);
    chk("lit_lu_cnt", a_cl, 16'd1);
    tick;
    chk("lit_lu_depE", a_rE, 5'd4);

    // SW reaches M, then 3 cycles of dhit=0 (flush raised mid-miss is ignored)
    drv(ST, 3'd2, 7'h00, 5'd1, 5'd2, 5'd7);
    tick;
    nop; tick;
    dhit = 1'b0; #1;
    chk("lit_dm_stallF", a_sF, 1'b1);
    chk("lit_dm_stallD", a_sD, 1'b1);
    tick;
    flush = 1'b1; #1;
    chk("lit_dm_flushD_masked", a_fD, 1'b0);
    tick;
    flush = 1'b0;
    tick;
    chk("lit_dm_memwM_held", a_mwM, 1'b1);
    chk("lit_dm_rdW_bubble", a_rW, 5'd0);
    chk("lit_dm_cnt", a_cd, 16'd3);
    dhit = 1'b1;
    tick;
    chk("lit_dm_done_memwM", a_mwM, 1'b0);

    // flush wins over load-use
    drv(LD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd6);
    tick;
    drv(R, 3'd0, 7'h00, 5'd6, 5'd0, 5'd8);
    flush = 1'b1; #1;
    chk("lit_fl_flushD", a_fD, 1'b1);
    chk("lit_fl_stallD", a_sD, 1'b0);
    chk("lit_fl_stallF", a_sF, 1'b0);
    tick;
    flush = 1'b0;
    chk("lit_fl_bubbleE", a_rE, 5'd0);
    chk("lit_fl_cnt_lu", a_cl, 16'd1);

    // MUL legal only with ENABLE_MUL=1
    drv(R, 3'd0, 7'h01, 5'd0, 5'd0, 5'd9);
    chk("lit_mul_ill_u0", a_ill, 1'b1);
    chk("lit_mul_ill_u1", b_ill, 1'b0);
    tick;
    chk("lit_mul_rdE_u0", a_rE, 5'd0);
    chk("lit_mul_aluE_u1", b_alu, 4'd5);
    chk("lit_mul_rdE_u1", b_rE, 5'd9);

    // JAL / BEQ
    drv(JL, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1);
    tick;
    chk("lit_jal_jumpE", a_jE, 1'b1);
    drv(BR, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0);
    tick;
    chk("lit_beq_aluE", a_alu, 3'd1);
    chk("lit_jal_jumpM", a_jpM, 1'b1);

    // five I-cache misses: 2-bit counter saturates at 3
    ihit = 1'b0;
    drv(7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
    chk("lit_im_ill_gated", a_ill, 1'b0);
    repeat (5) tick;
    chk("lit_im_cnt_u0", a_ci, 16'd5);
    chk("lit_im_cnt_u1", b_ci, 2'd3);
    ihit = 1'b1;

    foreach (tbl[i]) begin
      drv(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].r1, 5'd0, tbl[i].rd);
      tick;
    end
    nop; tick; tick; tick;

    // reset asserted in the middle of a load-use stall
    drv(LD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd3);
    tick;
    drv(R, 3'd0, 7'h00, 5'd3, 5'd0, 5'd4);
    chk("lit_rst_stallD_before", a_sD, 1'b1);
    reset = 1'b1; #1;
    chk("lit_rst_rdE", a_rE, 5'd0);
    chk("lit_rst_stallD", a_sD, 1'b0);
    chk("lit_rst_cnt_lu", a_cl, 16'd0);
    tick;
    reset = 1'b0;
    nop; tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
